// File: rtl/fitness_eval_ctrl.sv
// fitness_eval_ctrl: drives every input vector through the evolved circuit,
// holds each one for a settle time, then compares the circuit's response
// against the truth-table RAM. The number of matching output bits
// accumulated over the run is the fitness score.
module fitness_eval_ctrl #(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned N_OUT   = 2,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned SCORE_W = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               start,
    input  logic               abort,
    output logic [N_IN-1:0]    dut_in,
    input  logic [N_OUT-1:0]   dut_out,
    output logic [N_IN-1:0]    tt_addr,
    input  logic [N_OUT-1:0]   tt_data,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] fitness,
    output logic [31:0]        eval_count
);

    localparam int unsigned     CNT_W       = 8;
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_IN-1:0]    r_vec;
    logic [N_IN-1:0]    w_vec_nxt;
    logic [CNT_W-1:0]   r_settle;
    logic [CNT_W-1:0]   w_settle_nxt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [SCORE_W-1:0] w_fitness_nxt;
    logic [31:0]        w_eval_nxt;
    logic [N_OUT-1:0]   w_match;
    logic [SCORE_W-1:0] w_inc;
    logic               w_busy_nxt;

    // Number of output bits where the circuit agrees with the truth table.
    always_comb begin
        w_match = ~(dut_out ^ tt_data);
        w_inc   = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            w_inc = w_inc + SCORE_W'(w_match[i]);
        end
    end

    // Next state and next values of the run counters and result registers.
    always_comb begin
        w_state_nxt   = r_state;
        w_vec_nxt     = r_vec;
        w_settle_nxt  = r_settle;
        w_score_nxt   = r_score;
        w_fitness_nxt = fitness;
        w_eval_nxt    = eval_count;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt  = S_APPLY;
                    w_vec_nxt    = '0;
                    w_score_nxt  = '0;
                    w_settle_nxt = SETTLE_LOAD;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_settle == '0) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_settle_nxt = r_settle - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_score_nxt = r_score + w_inc;
                    // Compare before incrementing so the vector never wraps mid-run.
                    if (r_vec == LAST_VEC) begin
                        w_state_nxt   = S_DONE;
                        w_fitness_nxt = r_score + w_inc;
                        w_eval_nxt    = eval_count + 32'd1;
                    end else begin
                        w_state_nxt  = S_APPLY;
                        w_vec_nxt    = r_vec + N_IN'(1);
                        w_settle_nxt = SETTLE_LOAD;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == S_APPLY) || (w_state_nxt == S_SAMPLE);

    // State register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run counters and registered outputs, decoded from the next state.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_vec      <= '0;
            r_settle   <= '0;
            r_score    <= '0;
            fitness    <= '0;
            eval_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dut_in     <= '0;
            tt_addr    <= '0;
        end else begin
            r_vec      <= w_vec_nxt;
            r_settle   <= w_settle_nxt;
            r_score    <= w_score_nxt;
            fitness    <= w_fitness_nxt;
            eval_count <= w_eval_nxt;
            busy       <= w_busy_nxt;
            done       <= (w_state_nxt == S_DONE);
            dut_in     <= w_busy_nxt ? w_vec_nxt : '0;
            tt_addr    <= w_busy_nxt ? w_vec_nxt : '0;
        end
    end

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Directed bench for fitness_eval_ctrl with a registered truth-table RAM
// model and a circuit model whose error pattern is selected per test.
module tb_fitness_eval_ctrl;

    logic        clk_clk;
    logic        reset_reset;
    logic        start;
    logic        abort;
    logic [3:0]  dut_in;
    logic [1:0]  dut_out;
    logic [3:0]  tt_addr;
    logic [1:0]  tt_data;
    logic        busy;
    logic        done;
    logic [15:0] fitness;
    logic [31:0] eval_count;

    int total = 0;
    int bad   = 0;
    int mode  = 0;   // 0: exact, 1: all bits inverted, 2: bit 0 wrong on vector 5
    logic [1:0] tt_rom [16];

    fitness_eval_ctrl #(
        .N_IN(4), .N_OUT(2), .SETTLE(4), .SCORE_W(16)
    ) u_dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .start      (start),
        .abort      (abort),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .tt_addr    (tt_addr),
        .tt_data    (tt_data),
        .busy       (busy),
        .done       (done),
        .fitness    (fitness),
        .eval_count (eval_count)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    // Truth-table RAM: one cycle read latency.
    always @(posedge clk_clk) tt_data <= tt_rom[tt_addr];

    // Circuit under test: combinational response to dut_in.
    always_comb begin
        case (mode)
            0:       dut_out = tt_rom[dut_in];
            1:       dut_out = ~tt_rom[dut_in];
            default: dut_out = tt_rom[dut_in] ^ ((dut_in == 4'd5) ? 2'b01 : 2'b00);
        endcase
    end

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    // Full run from a start pulse: checks busy/done/dut_in/tt_addr every cycle
    // and the final fitness/eval_count. restart_at re-asserts start at that cycle.
    task automatic run_full(input string name, input logic [15:0] exp_fit,
                            input logic [31:0] exp_ec, input int restart_at);
        logic       e_busy;
        logic       e_done;
        logic [3:0] e_vec;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 82; k++) begin
            if (k > 0) step();
            start  = (k == restart_at);
            e_busy = (k < 80);
            e_done = (k == 80);
            e_vec  = (k < 80) ? 4'(k / 5) : 4'd0;
            total += 3;
            if (busy !== e_busy) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, e_busy);
            end
            if (done !== e_done) begin
                bad++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, k, done, e_done);
            end
            if (dut_in !== e_vec || tt_addr !== e_vec) begin
                bad++;
                $display("FAIL %s vector cycle %0d: dut_in %0d tt_addr %0d want %0d",
                         name, k, dut_in, tt_addr, e_vec);
            end
        end
        start = 1'b0;
        total += 2;
        if (fitness !== exp_fit) begin
            bad++;
            $display("FAIL %s fitness: got %0d want %0d", name, fitness, exp_fit);
        end
        if (eval_count !== exp_ec) begin
            bad++;
            $display("FAIL %s eval_count: got %0d want %0d", name, eval_count, exp_ec);
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || dut_in !== 4'd0 || tt_addr !== 4'd0 ||
            fitness !== 16'd0 || eval_count !== 32'd0) begin
            bad++;
            $display("FAIL reset: busy %b done %b dut_in %0d tt_addr %0d fit %0d ec %0d want all 0",
                     busy, done, dut_in, tt_addr, fitness, eval_count);
        end
        reset_reset = 1'b0;
        step();
    endtask

    task automatic test_match();
        mode = 0;
        run_full("match", 16'd32, 32'd1, -1);
    endtask

    task automatic test_abort();
        mode = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (36) step();           // after edge 36: vector 7
        total++;
        if (busy !== 1'b1 || dut_in !== 4'd7) begin
            bad++;
            $display("FAIL abort_pre: busy %b dut_in %0d want 1 / 7", busy, dut_in);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || dut_in !== 4'd0 || tt_addr !== 4'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_post: busy %b dut_in %0d tt_addr %0d done %b want 0",
                     busy, dut_in, tt_addr, done);
        end
        for (int k = 0; k < 60; k++) begin
            step();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_idle cycle %0d: done %b busy %b want 0", k, done, busy);
            end
        end
        total += 2;
        if (fitness !== 16'd32) begin
            bad++;
            $display("FAIL abort_fitness: got %0d want 32", fitness);
        end
        if (eval_count !== 32'd1) begin
            bad++;
            $display("FAIL abort_eval_count: got %0d want 1", eval_count);
        end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (busy !== 1'b0 || dut_in !== 4'd0) begin
                bad++;
                $display("FAIL start_abort cycle %0d: busy %b dut_in %0d want 0", k, busy, dut_in);
            end
            step();
        end
    endtask

    task automatic test_invert();
        mode = 1;
        run_full("invert", 16'd0, 32'd2, -1);
    endtask

    task automatic test_single_error();
        mode = 2;
        run_full("single_err", 16'd31, 32'd3, -1);
    endtask

    task automatic test_restart_busy();
        mode = 0;
        run_full("restart_busy", 16'd32, 32'd4, 15);
    endtask

    task automatic test_reset_mid_run();
        mode = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();           // after edge 50: vector 10
        total++;
        if (dut_in !== 4'd10) begin
            bad++;
            $display("FAIL reset_mid_pre: dut_in %0d want 10", dut_in);
        end
        reset_reset = 1'b1;
        step();
        reset_reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || dut_in !== 4'd0 || tt_addr !== 4'd0 ||
            fitness !== 16'd0 || eval_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: busy %b done %b dut_in %0d tt_addr %0d fit %0d ec %0d want all 0",
                     busy, done, dut_in, tt_addr, fitness, eval_count);
        end
        step();
        mode = 2;
        run_full("after_reset", 16'd31, 32'd1, -1);
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  seen;
        mode  = 0;
        start = 1'b1;                 // held high across DONE
        step();
        repeat (80) step();           // after edge 80: DONE
        total++;
        if (done !== 1'b1 || eval_count !== 32'd2) begin
            bad++;
            $display("FAIL b2b_done1: done %b ec %0d want 1 / 2", done, eval_count);
        end
        step();                       // after edge 81: IDLE, start ignored in DONE
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: busy %b done %b want 0", busy, done);
        end
        step();                       // after edge 82: second run begins
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || dut_in !== 4'd0) begin
            bad++;
            $display("FAIL b2b_restart: busy %b dut_in %0d want 1 / 0", busy, dut_in);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            step();
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        total += 2;
        if (!seen || n != 80) begin
            bad++;
            $display("FAIL b2b_latency: done seen %b after %0d cycles want 80", seen, n);
        end
        if (fitness !== 16'd32 || eval_count !== 32'd3) begin
            bad++;
            $display("FAIL b2b_result: fit %0d ec %0d want 32 / 3", fitness, eval_count);
        end
        step();
    endtask

    initial begin
        for (int v = 0; v < 16; v++) tt_rom[v] = 2'(v ^ (v >> 2));
        reset_reset = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        test_reset();
        test_match();
        test_abort();
        test_start_abort_idle();
        test_invert();
        test_single_error();
        test_restart_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fitness_eval_ctrl.md
# fitness_eval_ctrl

Sequences the exhaustive evaluation of one evolved logic circuit for the GA fitness loop. On a start request it walks every input vector through the circuit under test, waits a fixed settle time, compares the circuit's outputs against the expected truth table held in on-chip RAM, and accumulates the count of matching output bits as the fitness score. It sits in the FPGA fabric between the HPS-controlled register bank (start/abort, fitness readback) and the reconfigurable circuit array.

## Interface
- N_IN, 4, number of circuit inputs; 2^N_IN vectors per run
- N_OUT, 2, number of circuit outputs compared per vector
- SETTLE, 4, cycles each vector is held before sampling; legal range 2..255
- SCORE_W, 16, width of fitness/score; must satisfy 2^SCORE_W > N_OUT*2^N_IN
- clk_clk  in  1  single clock for the block, all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate the current run without result
- dut_in  out  N_IN  stimulus vector to circuit under test
- dut_out  in  N_OUT  circuit response (combinational path through array)
- tt_addr  out  N_IN  truth-table RAM read address; always equals dut_in
- tt_data  in  N_OUT  expected outputs; valid 1 cycle after tt_addr
- busy  out  1  high in APPLY and SAMPLE
- done  out  1  one-cycle pulse when a run completes
- fitness  out  SCORE_W  score of last completed run, held
- eval_count  out  32  number of completed runs, wraps at 2^32

## Operation
- Reset: state IDLE; dut_in, tt_addr, busy, done, fitness, eval_count, internal score, vector and settle counters all 0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: dut_in = 0. start=1 and abort=0 -> APPLY, vector=0, score=0, settle counter=SETTLE-1.
- APPLY: dut_in = vector; decrement settle counter each cycle; at 0 -> SAMPLE. Occupies exactly SETTLE cycles.
- SAMPLE: score += popcount(~(dut_out ^ tt_data)), N_OUT-bit compare. If vector == 2^N_IN-1 -> DONE, fitness <= score+increment on the same edge; else vector+1, settle counter reload, -> APPLY.
- DONE: done=1, busy=0, dut_in=0, eval_count+1 on entry edge; -> IDLE unconditionally.
- abort=1 in APPLY or SAMPLE: -> IDLE next edge; no done, fitness and eval_count unchanged, dut_in returns to 0. abort in IDLE/DONE has no effect; abort beats start in the same cycle.
- start while busy or in DONE: ignored (not queued).
- Vector counter is N_IN+1 bits internally or compares before increment; no wrap to 0 mid-run.
- Score arithmetic unsigned, SCORE_W bits, never overflows under the parameter constraint.

## Timing
- start seen at edge 0 -> busy=1, dut_in=0 after edge 0.
- Per vector: SETTLE + 1 cycles. Run length: 2^N_IN*(SETTLE+1) busy cycles, then 1 DONE cycle.
- Defaults: busy high for 80 cycles, done high in cycle 81 after start edge, fitness updated on the edge entering DONE.
- tt_data must be from the address driven since the first APPLY cycle; SETTLE>=2 guarantees RAM latency is covered.
- Back-to-back: start may be asserted in the cycle after DONE (IDLE) -> new run, minimum 1 IDLE cycle between runs.
- Reset mid-run: returns all outputs to reset values on the next edge, including fitness and eval_count.

## Test plan
- Defaults, dut_out model equals truth table for all 16 vectors, start pulse -> busy 80 cycles, done pulse in cycle 81, fitness=32, eval_count=1.
- dut_out = ~tt_data for every vector -> fitness=0, done timing unchanged, eval_count=2 after second run.
- Single bit 0 error only on vector 5 -> fitness=31; check dut_in/tt_addr step 0..15, each held 5 cycles, 0 in IDLE.
- Complete run (fitness=32), then start, abort during vector 7 -> busy low next cycle, no done, fitness stays 32, eval_count stays 1; start+abort same cycle in IDLE -> stays IDLE.
- start re-pulsed while busy at vector 3 -> ignored, run completes normally at cycle 81.
- reset_reset asserted at vector 10 -> all outputs 0 next cycle; subsequent start runs full 80+1 cycles with correct fitness.
